data_mem_ctrl: RTL and testbench

- Parametrised, byte-addressable, little-endian data memory with a valid/ready request port and a registered response port.
- Successor to the single-width 64-bit load/store memory. Adds:
  - byte, half, word and double access sizes, with sign or zero extension on loads;
  - misalignment and out-of-range error reporting;
  - response backpressure;
  - a hardware memory-clear sweep after reset.
- Sits between the MEM stage of the core and the data storage array.

---
 rtl/data_mem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// data_mem_ctrl : byte-addressable little-endian data memory, valid/ready
//                 request port, registered response, post-reset clear sweep.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module data_mem_ctrl #(
   parameter int XLEN        = 64,
   parameter int DEPTH_BYTES = 1024,
   parameter int ADDR_W      = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_write,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_unsigned,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [XLEN-1:0]   i_req_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [XLEN-1:0]   o_rsp_rdata,
   output logic              o_rsp_err
);

   localparam int NB     = XLEN / 8;
   localparam int OFF_W  = $clog2(NB);
   localparam int NWORDS = DEPTH_BYTES / NB;
   localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam bit HAS_DW = (XLEN == 64);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_cnt;
   logic               r_rsp_valid;
   logic [XLEN-1:0]    r_rsp_rdata;
   logic               r_rsp_err;

   // Word-organised storage: an aligned access never straddles two words.
   logic [XLEN-1:0]    r_mem [NWORDS];

   logic [IDX_W-1:0]   w_idx;
   logic [OFF_W-1:0]   w_off;
   logic [7:0]         w_lanes8;
   logic [2:0]         w_amask;
   logic [XLEN-1:0]    w_keep;
   logic               w_msb;
   logic [ADDR_W:0]    w_bytes;
   logic [ADDR_W:0]    w_end;
   logic               w_misalign;
   logic               w_range;
   logic               w_size_bad;
   logic               w_err;
   logic               w_accept;
   logic [NB-1:0]      w_be;
   logic [XLEN-1:0]    w_wdata_sh;
   logic [XLEN-1:0]    w_rsh;
   logic [XLEN-1:0]    w_load;

   assign w_idx      = i_req_addr[OFF_W +: IDX_W];
   assign w_off      = i_req_addr[OFF_W-1:0];
   assign w_rsh      = r_mem[w_idx] >> {w_off, 3'b000};
   assign w_wdata_sh = i_req_wdata << {w_off, 3'b000};

   always_comb begin
      w_lanes8 = 8'h01;
      w_amask  = 3'd0;
      w_keep   = XLEN'(64'hFF);
      w_msb    = w_rsh[7];
      case (i_req_size)
         2'd0: begin
            w_lanes8 = 8'h01;
            w_amask  = 3'd0;
            w_keep   = XLEN'(64'hFF);
            w_msb    = w_rsh[7];
         end
         2'd1: begin
            w_lanes8 = 8'h03;
            w_amask  = 3'd1;
            w_keep   = XLEN'(64'hFFFF);
            w_msb    = w_rsh[15];
         end
         2'd2: begin
            w_lanes8 = 8'h0F;
            w_amask  = 3'd3;
            w_keep   = XLEN'(64'hFFFF_FFFF);
            w_msb    = w_rsh[31];
         end
         default: begin
            w_lanes8 = 8'hFF;
            w_amask  = 3'd7;
            w_keep   = '1;
            w_msb    = w_rsh[XLEN-1];
         end
      endcase
   end

   // Range check is done one bit wider than the address so it cannot wrap.
   assign w_bytes    = (ADDR_W+1)'(1) << i_req_size;
   assign w_end      = {1'b0, i_req_addr} + w_bytes;
   assign w_range    = w_end > (ADDR_W+1)'(DEPTH_BYTES);
   assign w_misalign = |(i_req_addr[2:0] & w_amask);
   assign w_size_bad = (i_req_size == 2'd3) && !HAS_DW;
   assign w_err      = w_misalign || w_range || w_size_bad;

   assign w_be   = NB'(w_lanes8) << w_off;
   assign w_load = (w_rsh & w_keep) | ((!i_req_unsigned && w_msb) ? ~w_keep : '0);

   assign o_req_ready = (r_state == ST_RUN) && (!r_rsp_valid || i_rsp_ready);
   assign w_accept    = i_req_valid && o_req_ready;

   always_ff @(posedge clk) begin
      if (r_state == ST_INIT) begin
         r_mem[r_cnt] <= '0;
      end else if (w_accept && i_req_write && !w_err) begin
         for (int j = 0; j < NB; j++) begin
            if (w_be[j]) r_mem[w_idx][8*j +: 8] <= w_wdata_sh[8*j +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_cnt <= r_cnt + IDX_W'(1);
               if (r_cnt == IDX_W'(NWORDS - 1)) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (w_accept) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_err;
                  r_rsp_rdata <= (w_err || i_req_write) ? '0 : w_load;
               end else if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// tb_data_mem_ctrl : scoreboard bench for data_mem_ctrl with a byte-array model.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic        i_req_write = 1'b0;
   logic [1:0]  i_req_size = 2'd0;
   logic        i_req_unsigned = 1'b0;
   logic [63:0] i_req_addr = '0;
   logic [63:0] i_req_wdata = '0;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b1;
   logic [63:0] o_rsp_rdata;
   logic        o_rsp_err;

   always #5 clk = ~clk;

   data_mem_ctrl #(.XLEN(64), .DEPTH_BYTES(1024), .ADDR_W(64)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_req_valid    (i_req_valid),
      .o_req_ready    (o_req_ready),
      .i_req_write    (i_req_write),
      .i_req_size     (i_req_size),
      .i_req_unsigned (i_req_unsigned),
      .i_req_addr     (i_req_addr),
      .i_req_wdata    (i_req_wdata),
      .o_rsp_valid    (o_rsp_valid),
      .i_rsp_ready    (i_rsp_ready),
      .o_rsp_rdata    (o_rsp_rdata),
      .o_rsp_err      (o_rsp_err)
   );

   typedef struct packed {
      logic        err;
      logic [63:0] data;
   } exp_t;

   exp_t       q[$];
   logic [7:0] mem_m [1024];
   int         n_checks = 0;
   int         n_fail   = 0;
   bit         bp_random = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: memory as a flat byte array, results from plain arithmetic.
   function automatic exp_t model(input bit w, input logic [1:0] sz, input bit uns,
                                  input logic [63:0] a, input logic [63:0] wd);
      exp_t        r;
      int          b;
      logic [63:0] v;
      b = 1 << sz;
      r.err  = 1'b0;
      r.data = '0;
      if ((a % 64'(b)) != 0 || a > 64'd1024 || (a + 64'(b)) > 64'd1024) begin
         r.err = 1'b1;
         return r;
      end
      if (w) begin
         for (int i = 0; i < b; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
         return r;
      end
      v = '0;
      for (int i = 0; i < b; i++) v = v | (64'(mem_m[int'(a) + i]) << (8*i));
      if (!uns && b < 8 && v[8*b-1]) v = v | ~((64'd1 << (8*b)) - 64'd1);
      r.data = v;
      return r;
   endfunction

   task automatic do_req(input bit w, input logic [1:0] sz, input bit uns,
                         input logic [63:0] a, input logic [63:0] wd);
      int t = 0;
      i_req_valid    = 1'b1;
      i_req_write    = w;
      i_req_size     = sz;
      i_req_unsigned = uns;
      i_req_addr     = a;
      i_req_wdata    = wd;
      @(negedge clk);
      while (!o_req_ready) begin
         t++;
         if (t > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: request at %h not accepted within 200 cycles", a);
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
         @(negedge clk);
      end
      q.push_back(model(w, sz, uns, a, wd));
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      i_req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_init();
      int n = 0;
      while (n < 1000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (o_req_ready) break;
      end
      check("init_edges", 64'(n), 64'd128);
      @(posedge clk); #1;
   endtask

   // Monitor: pops one expectation per completed response handshake.
   initial begin
      exp_t        e;
      bit          ps = 1'b0;
      logic [63:0] pd = '0;
      logic        pe = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ps = 1'b0;
         end else begin
            if (ps) begin
               check("hold_rdata", o_rsp_rdata, pd);
               check("hold_valid_err", {62'd0, o_rsp_valid, o_rsp_err}, {62'd0, 1'b1, pe});
            end
            if (o_rsp_valid && !i_rsp_ready) check("stall_req_ready", {63'd0, o_req_ready}, 64'd0);
            if (o_rsp_valid && i_rsp_ready) begin
               if (q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_rsp: response data %h with no request outstanding", o_rsp_rdata);
               end else begin
                  e = q.pop_front();
                  check("rsp_rdata", o_rsp_rdata, e.data);
                  check("rsp_err", {63'd0, o_rsp_err}, {63'd0, e.err});
               end
            end
            ps = o_rsp_valid && !i_rsp_ready;
            pd = o_rsp_rdata;
            pe = o_rsp_err;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (bp_random) i_rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          w;
      bit          uns;
      logic [1:0]  sz;
      logic [63:0] a;
      for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_req_ready", {63'd0, o_req_ready}, 64'd0);
      check("reset_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
      check("reset_rsp_rdata", o_rsp_rdata, 64'd0);
      check("reset_rsp_err", {63'd0, o_rsp_err}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_init();

      do_req(1'b0, 2'd3, 1'b0, 64'd0, 64'd0);
      do_req(1'b1, 2'd3, 1'b0, 64'd16, 64'h8877_6655_4433_2211);
      do_req(1'b0, 2'd0, 1'b0, 64'd16, 64'd0);
      do_req(1'b0, 2'd1, 1'b0, 64'd18, 64'd0);
      do_req(1'b0, 2'd2, 1'b0, 64'd20, 64'd0);
      do_req(1'b0, 2'd2, 1'b1, 64'd20, 64'd0);
      do_req(1'b0, 2'd2, 1'b0, 64'd6, 64'd0);
      do_req(1'b1, 2'd3, 1'b0, 64'd1020, 64'hDEAD_BEEF_CAFE_F00D);
      do_req(1'b0, 2'd3, 1'b0, 64'd1016, 64'd0);
      do_req(1'b0, 2'd0, 1'b0, 64'd1023, 64'd0);
      do_req(1'b0, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0);
      idle(3);

      // Backpressure: hold the response and keep a second request waiting.
      i_rsp_ready = 1'b0;
      do_req(1'b0, 2'd3, 1'b0, 64'd16, 64'd0);
      i_req_valid = 1'b1;
      i_req_write = 1'b0;
      i_req_size  = 2'd1;
      i_req_addr  = 64'd18;
      repeat (5) begin
         @(negedge clk);
         check("bp_req_ready", {63'd0, o_req_ready}, 64'd0);
         check("bp_rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
         @(posedge clk); #1;
      end
      i_rsp_ready = 1'b1;
      do_req(1'b0, 2'd1, 1'b0, 64'd18, 64'd0);
      idle(3);
      check("bp_drain", 64'(q.size()), 64'd0);

      do_req(1'b1, 2'd0, 1'b0, 64'd3, 64'h0000_0000_0000_00A5);
      do_req(1'b0, 2'd0, 1'b0, 64'd3, 64'd0);
      idle(2);
      check("b2b_drain", 64'(q.size()), 64'd0);

      bp_random = 1'b1;
      for (int n = 0; n < 300; n++) begin
         w   = $urandom_range(0, 1) != 0;
         uns = $urandom_range(0, 1) != 0;
         sz  = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0:       a = {$urandom, $urandom};
            1:       a = 64'($urandom_range(1000, 1100));
            2, 3, 4: a = 64'($urandom_range(0, 63));
            default: a = 64'($urandom_range(0, 1023));
         endcase
         if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
         do_req(w, sz, uns, a, {$urandom, $urandom});
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      bp_random = 1'b0;
      i_rsp_ready = 1'b1;
      idle(5);
      check("random_drain", 64'(q.size()), 64'd0);

      // Reset with a stalled response outstanding.
      i_rsp_ready = 1'b0;
      do_req(1'b0, 2'd3, 1'b0, 64'd16, 64'd0);
      i_req_valid = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
      check("midrst_req_ready", {63'd0, o_req_ready}, 64'd0);
      q.delete();
      for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      i_rsp_ready = 1'b1;
      wait_init();
      do_req(1'b0, 2'd3, 1'b0, 64'd16, 64'd0);
      idle(3);
      check("final_drain", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
